// File: rtl/ecc_scrub_ctrl.sv
// Background SECDED scrubber: walks one cache data array, rewrites corrected
// words, logs uncorrectable ones and yields the array port to demand traffic.
module ecc_scrub_ctrl #(
  parameter int ADDR_W   = 10,
  parameter int DEPTH    = 1024,
  parameter int INTERVAL = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EN,
  input  logic              DEM_BUSY,
  input  logic              DEM_WE,
  input  logic [ADDR_W-1:0] DEM_ADDR,
  output logic              MEM_REQ,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [71:0]       MEM_WDATA,
  input  logic [71:0]       MEM_RDATA,
  output logic [71:0]       DEC_IN,
  input  logic [71:0]       DEC_OUT,
  input  logic [7:0]        DEC_SYN,
  input  logic              DEC_SGL,
  input  logic              DEC_DBL,
  output logic [15:0]       CE_CNT,
  output logic [15:0]       UE_CNT,
  output logic [ADDR_W-1:0] UE_ADDR,
  output logic [7:0]        UE_SYN,
  output logic              UE_IRQ,
  input  logic              IRQ_CLR,
  output logic              PASS_DONE
);

  typedef enum logic [2:0] {IDLE, RD, CHK, WB, NEXT} state_e;

  localparam int                CNT_W     = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(INTERVAL - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [71:0]         wb_q, wb_d;
  logic [15:0]         ce_q, ce_d;
  logic [15:0]         ue_q, ue_d;
  logic [ADDR_W-1:0]   ue_addr_q, ue_addr_d;
  logic [7:0]          ue_syn_q, ue_syn_d;
  logic                irq_q, irq_d;
  logic                pass_q, pass_d;
  logic                stale;
  logic                ue_set;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // A demand write to the word being scrubbed makes the corrected copy stale.
  assign stale  = DEM_WE && (DEM_ADDR == addr_q);
  assign ue_set = (state_q == CHK) && !DEC_SGL && DEC_DBL;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      wb_q      <= '0;
      ce_q      <= '0;
      ue_q      <= '0;
      ue_addr_q <= '0;
      ue_syn_q  <= '0;
      irq_q     <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      wb_q      <= wb_d;
      ce_q      <= ce_d;
      ue_q      <= ue_d;
      ue_addr_q <= ue_addr_d;
      ue_syn_q  <= ue_syn_d;
      irq_q     <= irq_d;
      pass_q    <= pass_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    wb_d      = wb_q;
    ce_d      = ce_q;
    ue_d      = ue_q;
    ue_addr_d = ue_addr_q;
    ue_syn_d  = ue_syn_q;
    pass_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!EN) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = RD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RD: begin
        if (!DEM_BUSY) state_d = CHK;
      end
      CHK: begin
        if (DEC_SGL) begin
          ce_d    = sat_inc(ce_q);
          wb_d    = DEC_OUT;
          state_d = stale ? NEXT : WB;
        end else if (DEC_DBL) begin
          ue_d      = sat_inc(ue_q);
          ue_addr_d = addr_q;
          ue_syn_d  = DEC_SYN;
          state_d   = NEXT;
        end else begin
          state_d = NEXT;
        end
      end
      WB: begin
        if (stale || !DEM_BUSY) state_d = NEXT;
      end
      NEXT: begin
        if (addr_q == ADDR_LAST) begin
          addr_d = '0;
          pass_d = 1'b1;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A fresh UE outranks a simultaneous clear so no event is lost.
  always_comb begin
    irq_d = irq_q;
    if (ue_set)       irq_d = 1'b1;
    else if (IRQ_CLR) irq_d = 1'b0;
  end

  always_comb begin
    MEM_REQ = 1'b0;
    MEM_WE  = 1'b0;
    case (state_q)
      RD: MEM_REQ = !DEM_BUSY;
      WB: begin
        if (!DEM_BUSY && !stale) begin
          MEM_REQ = 1'b1;
          MEM_WE  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign MEM_ADDR  = addr_q;
  assign MEM_WDATA = wb_q;
  assign DEC_IN    = MEM_RDATA;
  assign CE_CNT    = ce_q;
  assign UE_CNT    = ue_q;
  assign UE_ADDR   = ue_addr_q;
  assign UE_SYN    = ue_syn_q;
  assign UE_IRQ    = irq_q;
  assign PASS_DONE = pass_q;

endmodule

// File: doc/ecc_scrub_ctrl.md
Name: ecc_scrub_ctrl

Overview:
Background scrubber that sequences the 72-bit SECDED decoder (64 data + 8 check) over one cache data array. It periodically reads each codeword and passes it through the decoder. Single-bit errors are written back corrected; double-bit errors are logged and raise an interrupt. The block shares the array port with demand traffic, and demand always has priority.

Parameters:
ADDR_W, 10, array address width
DEPTH, 1024, number of codewords scrubbed per pass (≤ 2^ADDR_W)
INTERVAL, 256, idle cycles between consecutive scrub reads (≥1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
EN  in  1  scrub enable
DEM_BUSY  in  1  demand owns array port this cycle
DEM_WE  in  1  demand write this cycle
DEM_ADDR  in  ADDR_W  demand address
MEM_REQ  out  1  scrubber array access
MEM_WE  out  1  1=write, 0=read
MEM_ADDR  out  ADDR_W  scrub address
MEM_WDATA  out  72  corrected codeword
MEM_RDATA  in  72  read data, valid 1 cycle after read request
DEC_IN  out  72  codeword to decoder (= MEM_RDATA)
DEC_OUT  in  72  corrected codeword (combinational decoder)
DEC_SYN  in  8  syndrome
DEC_SGL  in  1  single error
DEC_DBL  in  1  double error
CE_CNT  out  16  corrected-error count
UE_CNT  out  16  uncorrectable-error count
UE_ADDR  out  ADDR_W  address of most recent UE
UE_SYN  out  8  syndrome of most recent UE
UE_IRQ  out  1  sticky UE interrupt
IRQ_CLR  in  1  clears UE_IRQ
PASS_DONE  out  1  one-cycle pulse at end of full pass

Behaviour:
- Reset: state IDLE, scrub address 0, interval counter 0. CE_CNT, UE_CNT, UE_ADDR, UE_SYN, UE_IRQ and PASS_DONE all 0. MEM_REQ and MEM_WE are 0. Reset mid-operation abandons any pending writeback.
- FSM states: IDLE, RD, CHK, WB, NEXT.
- IDLE: while EN=1 the interval counter increments. When it reaches INTERVAL-1, clear the counter and go to RD. While EN=0 the counter holds at 0.
- RD: assert MEM_REQ=1, MEM_WE=0, MEM_ADDR=scrub address combinationally only when DEM_BUSY=0, then go to CHK. If DEM_BUSY=1, drive MEM_REQ=0 and stay in RD.
- CHK (read data valid): DEC_IN=MEM_RDATA; the decoder outputs are sampled this cycle.
  - DEC_SGL=1: CE_CNT++, register DEC_OUT as the writeback word, go to WB.
  - DEC_DBL=1: UE_CNT++, UE_ADDR←address, UE_SYN←DEC_SYN, UE_IRQ←1, go to NEXT. No write is issued.
  - Otherwise go to NEXT.
- WB: MEM_REQ=1, MEM_WE=1, MEM_WDATA=registered word when DEM_BUSY=0, then go to NEXT. Stall while DEM_BUSY=1.
- Stale-data rule: a demand write to the scrub address in CHK or WB (DEM_WE=1 and DEM_ADDR matches) cancels the writeback. The FSM goes straight to NEXT and CE_CNT is still incremented.
- NEXT: advance the address. If it equals DEPTH-1, wrap to 0 and pulse PASS_DONE for 1 cycle. Return to IDLE.
- Dropping EN mid-operation: the current scrub completes through NEXT, then the FSM holds in IDLE.
- Counters saturate at 16'hFFFF.
- UE_IRQ: IRQ_CLR clears it. If a new UE coincides with IRQ_CLR in the same cycle, the set wins.
- Minimum clean-word cycle count, no contention: INTERVAL (IDLE) + 1 (RD) + 1 (CHK) + 1 (NEXT). A corrected word adds 1 cycle (WB).
- DEC_IN is a pure passthrough of MEM_RDATA.

Test Plan:
1. DEPTH=4, INTERVAL=4, all words 72'h0, EN=1 → reads at addresses 0,1,2,3 each 7 cycles apart, no writes, PASS_DONE pulses once after address 3, counters stay 0.
2. Address 2 holds 72'h1 (single data-bit flip) → DEC_SGL=1; one write of 72'h0 to address 2 the cycle after CHK; CE_CNT=1.
3. Address 1 holds 72'h3 (double data-bit flip) → no write; UE_CNT=1, UE_ADDR=1, UE_SYN=DEC_SYN, UE_IRQ=1. UE_IRQ holds until IRQ_CLR; UE and IRQ_CLR in the same cycle leave UE_IRQ=1.
4. DEM_BUSY=1 for 5 cycles on entry to RD, then again during WB → MEM_REQ=0 throughout each busy window; the access issues on the first free cycle; data is correct.
5. Address 2 holds 72'h8000…0 (single check-bit flip), plus a demand write with DEM_ADDR=2 during WB → no scrub write is issued; CE_CNT=1; address advances to 3.
6. rst=1 asserted in WB → next cycle MEM_REQ=0, all counters/flags 0, address 0, state IDLE.
